// File: rtl/mul_div_pkg.sv
// Shared definitions for the RISC-V M-extension multiply/divide unit:
// funct3 op encodings, FSM state type and small decode helpers.
package mul_div_pkg;

   // funct3 encodings of the M-extension operations
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   // Control FSM states
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREP     = 3'd1,
      ST_MUL_WAIT = 3'd2,
      ST_DIV_ITER = 3'd3,
      ST_FIX      = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   // All divide/remainder ops have funct3[2] set
   function automatic logic is_div_op(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, MSB first,
// DATA_WIDTH iterations after a load. done is high in the cycle whose clock
// edge performs the final iteration, so quotient/remainder are valid from the
// following cycle on.
module div_iter_radix2 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] numerator,
   input  logic [DATA_WIDTH-1:0] denominator,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  done
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);

   logic [W-1:0]  rem_q, quo_q, den_q;
   logic [CW-1:0] cnt_q;
   logic [W:0]    rem_shift;
   logic [W:0]    trial;

   // Shift in the next numerator bit and trial-subtract the divisor; trial[W]
   // acts as the borrow because the shifted remainder is below 2*divisor.
   always_comb begin
      rem_shift = {rem_q, quo_q[W-1]};
      trial     = rem_shift - {1'b0, den_q};
   end

   // Iteration registers: load operands, then restore or keep each cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem_q <= '0;
         quo_q <= '0;
         den_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= numerator;
         den_q <= denominator;
         cnt_q <= CW'(W);
      end else if (cnt_q != '0) begin
         if (!trial[W]) begin
            rem_q <= trial[W-1:0];
            quo_q <= {quo_q[W-2:0], 1'b1};
         end else begin
            rem_q <= rem_shift[W-1:0];
            quo_q <= {quo_q[W-2:0], 1'b0};
         end
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign done      = (cnt_q == CW'(1));

endmodule

// File: rtl/mul_div_unit.sv
// RISC-V M-extension execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Handshake: start_in is taken on a rising edge only while ready_out=1
// (IDLE or DONE); done_out is a one-cycle pulse and result_out/flags are
// valid with it, result_out holding until the next done_out.
// Optional macro MUL_DIV_UNIT_DIV_CACHE_EN: remember the last full divide
// so an identical divide/remainder pair skips the iteration phase.
module mul_div_unit
   import mul_div_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_in,
   input  logic [2:0]            op_in,
   input  logic [DATA_WIDTH-1:0] x_in,
   input  logic [DATA_WIDTH-1:0] y_in,
   output logic                  ready_out,
   output logic                  done_out,
   output logic [DATA_WIDTH-1:0] result_out,
   output logic                  div_by_zero_out,
   output logic                  ov_out
);

   localparam int             W        = DATA_WIDTH;
   localparam logic [1:0]     MUL_LAST = 2'(MUL_STAGES - 1);
   localparam logic [W-1:0]   MOST_NEG = {1'b1, {(W-1){1'b0}}};

   state_t         state_q, state_d;
   logic [2:0]     op_q;
   logic [W-1:0]   x_q, y_q;
   logic [W-1:0]   mag_x_q, mag_y_q;
   logic           neg_q;
   logic [1:0]     mul_cnt_q;
   logic           accept;

   logic           x_signed, y_signed, xs, ys;
   logic [W-1:0]   x_mag, y_mag;
   logic           div_op, is_dbz, is_ovf, sel_quo, neg_d;
   logic [W-1:0]   short_res;

   logic [2*W-1:0] prod_pipe [MUL_STAGES];
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   div_quo, div_rem, quo_mag, rem_mag, div_mag, div_fix;
   logic [W-1:0]   fix_res;
   logic           div_load, div_done;
   logic           cache_hit;

   assign ready_out = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign done_out  = (state_q == ST_DONE);
   assign accept    = start_in && ready_out;

   // Operand decode: signedness, magnitudes, result sign and shortcut cases
   always_comb begin
      x_signed  = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                  (op_q == OP_DIV)  || (op_q == OP_REM);
      y_signed  = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
      xs        = x_signed && x_q[W-1];
      ys        = y_signed && y_q[W-1];
      x_mag     = xs ? -x_q : x_q;
      y_mag     = ys ? -y_q : y_q;
      div_op    = is_div_op(op_q);
      sel_quo   = (op_q == OP_DIV) || (op_q == OP_DIVU);
      is_dbz    = div_op && (y_q == '0);
      is_ovf    = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                  (x_q == MOST_NEG) && (y_q == '1);
      // remainder takes the dividend's sign, everything else xs^ys
      neg_d     = (div_op && !sel_quo) ? xs : (xs ^ ys);
      short_res = '0;
      if (is_dbz)
         short_res = sel_quo ? '1 : x_q;
      else if (is_ovf)
         short_res = sel_quo ? x_q : '0;
   end

   // Multiplier: unsigned magnitude product through MUL_STAGES registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MUL_STAGES; i++) prod_pipe[i] <= '0;
      end else begin
         prod_pipe[0] <= {{W{1'b0}}, mag_x_q} * {{W{1'b0}}, mag_y_q};
         for (int i = 1; i < MUL_STAGES; i++) prod_pipe[i] <= prod_pipe[i-1];
      end
   end

   assign div_load = (state_q == ST_PREP) && (state_d == ST_DIV_ITER);

   div_iter_radix2 #(
      .DATA_WIDTH (W)
   ) u_div (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (div_load),
      .numerator   (x_mag),
      .denominator (y_mag),
      .quotient    (div_quo),
      .remainder   (div_rem),
      .done        (div_done)
   );

`ifdef MUL_DIV_UNIT_DIV_CACHE_EN
   logic         cache_valid_q, cache_signed_q, hit_q, div_signed;
   logic [W-1:0] cache_x_q, cache_y_q, cache_quo_q, cache_rem_q;

   assign div_signed = (op_q == OP_DIV) || (op_q == OP_REM);
   assign cache_hit  = cache_valid_q && (cache_x_q == x_q) && (cache_y_q == y_q) &&
                       (cache_signed_q == div_signed);
   assign quo_mag    = hit_q ? cache_quo_q : div_quo;
   assign rem_mag    = hit_q ? cache_rem_q : div_rem;

   // Cache: capture operands and magnitudes of each completed full divide
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cache_valid_q  <= 1'b0;
         cache_signed_q <= 1'b0;
         cache_x_q      <= '0;
         cache_y_q      <= '0;
         cache_quo_q    <= '0;
         cache_rem_q    <= '0;
         hit_q          <= 1'b0;
      end else begin
         if (state_q == ST_PREP) hit_q <= cache_hit;
         if ((state_q == ST_FIX) && div_op && !hit_q) begin
            cache_valid_q  <= 1'b1;
            cache_signed_q <= div_signed;
            cache_x_q      <= x_q;
            cache_y_q      <= y_q;
            cache_quo_q    <= div_quo;
            cache_rem_q    <= div_rem;
         end
      end
   end
`else
   assign cache_hit = 1'b0;
   assign quo_mag   = div_quo;
   assign rem_mag   = div_rem;
`endif

   // Final sign fix-up and half/quotient/remainder selection
   always_comb begin
      prod_fix = neg_q ? -prod_pipe[MUL_STAGES-1] : prod_pipe[MUL_STAGES-1];
      div_mag  = sel_quo ? quo_mag : rem_mag;
      div_fix  = neg_q ? -div_mag : div_mag;
      if (div_op)
         fix_res = div_fix;
      else if (op_q == OP_MUL)
         fix_res = prod_fix[W-1:0];
      else
         fix_res = prod_fix[2*W-1:W];
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (start_in) state_d = ST_PREP;
         ST_PREP: begin
            if (is_dbz || is_ovf) state_d = ST_DONE;
            else if (div_op)      state_d = cache_hit ? ST_FIX : ST_DIV_ITER;
            else                  state_d = ST_MUL_WAIT;
         end
         ST_MUL_WAIT: if (mul_cnt_q == MUL_LAST) state_d = ST_FIX;
         ST_DIV_ITER: if (div_done) state_d = ST_FIX;
         ST_FIX:      state_d = ST_DONE;
         ST_DONE:     state_d = start_in ? ST_PREP : ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Multiplier wait counter, cleared outside MUL_WAIT
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    mul_cnt_q <= '0;
      else if (state_q != ST_MUL_WAIT) mul_cnt_q <= '0;
      else                             mul_cnt_q <= mul_cnt_q + 1'b1;
   end

   // Operand latch, magnitudes/sign capture and result/flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q            <= '0;
         x_q             <= '0;
         y_q             <= '0;
         mag_x_q         <= '0;
         mag_y_q         <= '0;
         neg_q           <= 1'b0;
         result_out      <= '0;
         div_by_zero_out <= 1'b0;
         ov_out          <= 1'b0;
      end else begin
         if (accept) begin
            op_q <= op_in;
            x_q  <= x_in;
            y_q  <= y_in;
         end
         if (state_q == ST_PREP) begin
            mag_x_q <= x_mag;
            mag_y_q <= y_mag;
            neg_q   <= neg_d;
            if (is_dbz || is_ovf) begin
               result_out      <= short_res;
               div_by_zero_out <= is_dbz;
               ov_out          <= is_ovf;
            end
         end
         if (state_q == ST_FIX) begin
            result_out      <= fix_res;
            div_by_zero_out <= 1'b0;
            ov_out          <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (DATA_WIDTH=32, MUL_STAGES=2).
// Reference model computes results with plain 64-bit arithmetic; latency
// and the optional divide cache (MUL_DIV_UNIT_DIV_CACHE_EN) are modelled too.
module tb_mul_div_unit;

   localparam int W   = 32;
   localparam int MST = 2;

   localparam logic [2:0] T_MUL = 3'd0, T_MULH = 3'd1, T_MULHSU = 3'd2, T_MULHU = 3'd3;
   localparam logic [2:0] T_DIV = 3'd4, T_DIVU = 3'd5, T_REM = 3'd6, T_REMU = 3'd7;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start_in;
   logic [2:0]    op_in;
   logic [W-1:0]  x_in, y_in;
   logic          ready_out, done_out, div_by_zero_out, ov_out;
   logic [W-1:0]  result_out;

   int n_vec     = 0;
   int n_miscmp  = 0;

   // Model of the divide cache
   logic          cache_v = 1'b0;
   logic          cache_s;
   logic [W-1:0]  cache_x, cache_y;

   mul_div_unit #(
      .DATA_WIDTH (W),
      .MUL_STAGES (MST)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start_in        (start_in),
      .op_in           (op_in),
      .x_in            (x_in),
      .y_in            (y_in),
      .ready_out       (ready_out),
      .done_out        (done_out),
      .result_out      (result_out),
      .div_by_zero_out (div_by_zero_out),
      .ov_out          (ov_out)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Architectural reference: result, flags, latency, and whether a full divide ran
   function automatic void model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic dz, output logic ov,
                                 output int lat, output logic full_div);
      longint      sx, sy, p;
      logic [63:0] t;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      dz = 1'b0; ov = 1'b0; full_div = 1'b0; lat = MST + 3; r = '0;
      case (op)
         T_MUL:    begin t = {32'b0, x} * {32'b0, y}; r = t[31:0]; end
         T_MULH:   begin p = sx * sy; t = p; r = t[63:32]; end
         T_MULHSU: begin p = sx * longint'({32'b0, y}); t = p; r = t[63:32]; end
         T_MULHU:  begin t = {32'b0, x} * {32'b0, y}; r = t[63:32]; end
         default: begin
            if (y == 0) begin
               dz = 1'b1; lat = 2;
               r  = (op == T_DIV || op == T_DIVU) ? 32'hFFFF_FFFF : x;
            end else if ((op == T_DIV || op == T_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               ov = 1'b1; lat = 2;
               r  = (op == T_DIV) ? x : 32'h0;
            end else begin
               full_div = 1'b1; lat = W + 3;
               case (op)
                  T_DIV:   begin p = sx / sy; t = p; r = t[31:0]; end
                  T_REM:   begin p = sx % sy; t = p; r = t[31:0]; end
                  T_DIVU:  r = x / y;
                  default: r = x % y;
               endcase
            end
         end
      endcase
   endfunction

   // Issue one op (caller sits at a negedge) and check its completion.
   // poke pulses start_in with junk operands while the unit is busy.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
      logic [W-1:0] er;
      logic         edz, eov, full, sgn, got;
      int           elat, lat, guard;
      model(op, x, y, er, edz, eov, elat, full);
      sgn = (op == T_DIV) || (op == T_REM);
`ifdef MUL_DIV_UNIT_DIV_CACHE_EN
      if (full && cache_v && cache_x == x && cache_y == y && cache_s == sgn) elat = 3;
`endif
      if (full) begin
         cache_v = 1'b1; cache_x = x; cache_y = y; cache_s = sgn;
      end
      guard = 0;
      while (!ready_out && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("ready_before_start", ready_out, 1'b1);
      start_in = 1'b1; op_in = op; x_in = x; y_in = y;
      @(posedge clk);
      #1;
      start_in = 1'b0; op_in = 3'($urandom); x_in = $urandom; y_in = $urandom;
      got = 1'b0; lat = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) check("ready_drop", ready_out, 1'b0);
         if (poke && k == 4) start_in = 1'b0;
         if (done_out) begin
            got = 1'b1; lat = k;
            break;
         end
         if (poke && k == 3) begin
            start_in = 1'b1; op_in = 3'($urandom); x_in = $urandom; y_in = $urandom;
         end
      end
      start_in = 1'b0;
      check($sformatf("done_seen op%0d", op), got, 1'b1);
      if (got) begin
         check($sformatf("latency op%0d", op), lat, elat);
         check($sformatf("result op%0d x=%0h y=%0h", op, x, y), result_out, er);
         check($sformatf("dbz op%0d", op), div_by_zero_out, edz);
         check($sformatf("ov op%0d", op), ov_out, eov);
         check("ready_at_done", ready_out, 1'b1);
      end
   endtask

   // Reset while a divide is in flight: no completion may follow
   task automatic reset_mid_op();
      int seen;
      start_in = 1'b1; op_in = T_DIV; x_in = 32'hFFFF_FFF9; y_in = 32'd2;
      @(posedge clk);
      #1 start_in = 1'b0;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst_ready", ready_out, 1'b1);
      check("rst_done", done_out, 1'b0);
      check("rst_result", result_out, 32'h0);
      check("rst_flags", {div_by_zero_out, ov_out}, 2'b00);
      cache_v = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done_out) seen++;
      end
      check("no_done_after_reset", seen, 0);
      check("ready_after_reset", ready_out, 1'b1);
   endtask

   initial begin
      logic [2:0]   op;
      logic [W-1:0] x, y, lx, ly;
      reset_n = 1'b0; start_in = 1'b0; op_in = '0; x_in = '0; y_in = '0;
      repeat (3) @(negedge clk);
      check("reset_ready", ready_out, 1'b1);
      check("reset_done", done_out, 1'b0);
      check("reset_result", result_out, 32'h0);
      check("reset_flags", {div_by_zero_out, ov_out}, 2'b00);
      reset_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_op(T_MUL,    32'h7FFF_FFFF, 32'd2, 1'b0);
      run_op(T_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(T_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(T_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(T_DIV,    32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(T_REM,    32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(T_DIVU,   32'd100, 32'd7, 1'b0);
      run_op(T_REMU,   32'd100, 32'd7, 1'b0);
      run_op(T_DIVU,   32'd100, 32'd0, 1'b0);
      run_op(T_REM,    32'd100, 32'd0, 1'b0);
      run_op(T_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(T_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(T_DIV,    32'd1000, 32'd7, 1'b0);
      run_op(T_REM,    32'd1000, 32'd7, 1'b0);
      run_op(T_REMU,   32'd1000, 32'd7, 1'b0);
      run_op(T_DIVU,   32'd12345, 32'd67, 1'b1);
      run_op(T_MULHSU, 32'h8000_0000, 32'd3, 1'b1);
      @(negedge clk);
      reset_mid_op();

      // Randomised mix, back-to-back issue
      lx = 32'd1; ly = 32'd1;
      for (int i = 0; i < 300; i++) begin
         op = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: begin x = $urandom; y = $urandom; end
            1: begin x = $urandom; y = 32'h0; end
            2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            3: begin
               x = $urandom_range(0, 50); y = $urandom_range(1, 50);
               if ($urandom_range(0, 1) == 1) x = -x;
               if ($urandom_range(0, 1) == 1) y = -y;
            end
            4: begin x = lx; y = ly; end
            default: begin x = $urandom; y = $urandom_range(1, 9); end
         endcase
         run_op(op, x, y, $urandom_range(0, 9) == 0);
         lx = x; ly = y;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
